// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding, common to the
// buffered transmitter and the uart_rs receiver.
package uart_pkg;

    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int OVERSAMPLE = 16;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Transmit FIFO: synchronous, registered pointers, full/empty derived from an
// occupancy count; writes into a full FIFO are dropped and flagged.
module tx_fifo
    import uart_pkg::*;
#(
    parameter int DW = DBIT,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          wr_ok;
    logic          rd_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    // Full is checked before any same-cycle pop, so a write at full is always dropped.
    always_comb begin
        wr_ok      = wr_en & ~full;
        rd_ok      = rd_en & ~empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en & full;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small FIFO; bit timing comes from a 16x
// oversample tick, and tx is registered from the next-state decode.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DBIT    = uart_pkg::DBIT,
    parameter int SB_TICK = uart_pkg::SB_TICK,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int TW = 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    tx_state_t       state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [NW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            pop;
    logic [DBIT-1:0] fifo_data;
    logic            fifo_empty;

    tx_fifo #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign empty        = fifo_empty;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != TX_IDLE);
    assign tx_done_tick = done_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                // Leave IDLE immediately, without waiting for a tick.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = TX_START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (s_tick) begin
                    if (tick_q == TW'(OVERSAMPLE - 1)) begin
                        state_d = TX_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (s_tick) begin
                    if (tick_q == TW'(OVERSAMPLE - 1)) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == NW'(DBIT - 1)) begin
                            state_d = TX_STOP;
                        end else begin
                            bit_d = bit_q + NW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (s_tick) begin
                    if (tick_q == TW'(SB_TICK - 1)) begin
                        state_d = TX_IDLE;
                        tick_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the state being entered so tx lines up with state_q.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: vector table, directed frame
// sequences, and randomized writes against a frame-timeline reference model.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx, tx_busy, tx_done_tick;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .DBIT    (8),
        .SB_TICK (16),
        .FIFO_AW (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       tick;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_tx;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t        tbl [9];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned edge_n = 0;
    bit          tick_en = 0;
    bit          model_chk = 0;
    logic [7:0]  rxq [$];
    logic [7:0]  sentq [$];
    logic [7:0]  mq [$];
    int unsigned done_edges [$];

    // Reference model: frame timeline computed from the pop edge.
    bit          m_active = 0;
    int unsigned m_t16 = 0;
    int unsigned m_d = 0;
    logic [7:0]  m_byte = '0;
    logic        m_ovf = 1'b0;

    // Receiver (uart_rs-style): samples mid-bit in units of s_tick.
    bit          mon_active = 0;
    bit          mon_prev_tick = 0;
    bit          mon_prev_rst = 1;
    logic        mon_last_tx = 1'b0;
    int unsigned mon_ticks = 0;
    int unsigned mon_bi = 0;
    logic [7:0]  mon_sh = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic cycle(input logic wr, input logic [7:0] d);
        int unsigned k;
        int unsigned bi;
        bit          idle_b;
        bit          full_b;
        logic        busy_e;
        logic        tx_e;
        k       = edge_n + 1;
        wr_en   = wr;
        wr_data = d;
        s_tick  = tick_en && (k % 4 == 0);
        if (reset) begin
            mq.delete();
            m_active = 0;
            m_ovf    = 1'b0;
        end else begin
            idle_b = !(m_active && k <= m_d);
            full_b = (mq.size() == 4);
            m_ovf  = wr && full_b;
            if (idle_b && mq.size() > 0) begin
                m_byte   = mq.pop_front();
                sentq.push_back(m_byte);
                m_active = 1;
                m_t16    = (k / 4 + 1) * 4 + 60;
                m_d      = m_t16 + 576;
            end
            if (wr && !full_b) mq.push_back(d);
        end
        @(posedge clk);
        edge_n = k;
        #1;
        if (tx_done_tick === 1'b1) done_edges.push_back(edge_n);
        if (model_chk) begin
            busy_e = m_active && edge_n < m_d;
            if (busy_e && edge_n >= m_t16 && edge_n < m_t16 + 512) begin
                bi   = (edge_n - m_t16) / 64;
                tx_e = m_byte[bi];
            end else begin
                tx_e = !(busy_e && edge_n < m_t16);
            end
            chk("model_tx", tx, tx_e);
            chk("model_busy", tx_busy, busy_e);
            chk("model_done", tx_done_tick, m_active && edge_n == m_d);
            chk("model_empty", empty, mq.size() == 0);
            chk("model_full", full, mq.size() == 4);
            chk("model_overflow", overflow, m_ovf);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        reset = 1'b0;
        rxq.delete();
        done_edges.delete();
        sentq.delete();
    endtask

    task automatic run_until_rx(input string name, input int unsigned n, input int unsigned budget);
        int unsigned c;
        c = 0;
        while (rxq.size() < n && c < budget) begin
            cycle(1'b0, 8'h00);
            c++;
        end
        chk(name, rxq.size(), n);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic chk_rx(input string name, input int unsigned idx, input logic [7:0] exp);
        chk(name, (idx < rxq.size()) ? {24'h0, rxq[idx]} : 32'hFFFF_FFFF, {24'h0, exp});
    endtask

    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (mon_prev_rst) begin
                mon_active = 0;
            end else if (mon_active) begin
                if (mon_prev_tick) begin
                    mon_ticks++;
                    if (mon_ticks % 16 == 8) begin
                        mon_bi = mon_ticks / 16;
                        if (mon_bi == 0) begin
                            chk("rx_start_bit", tx, 1'b0);
                        end else if (mon_bi <= 8) begin
                            mon_sh[mon_bi-1] = tx;
                        end else begin
                            chk("rx_stop_bit", tx, 1'b1);
                            rxq.push_back(mon_sh);
                            mon_active = 0;
                        end
                    end
                end
            end else if (tx === 1'b0 && mon_last_tx === 1'b1) begin
                mon_active = 1;
                mon_ticks  = 0;
            end
            mon_last_tx   = tx;
            mon_prev_tick = s_tick;
            mon_prev_rst  = reset;
        end
    end

    initial begin : main
        logic [9:0]  frame55;
        int unsigned bad [10];
        int unsigned nbad;
        int unsigned c;
        int unsigned pm;
        logic        wr;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        s_tick  = 1'b0;

        //           rst   wr    d      tick  empty full  ovf   tx    busy  done
        tbl[0] = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset, first-write latency, fill to full and overflow on the sixth byte.
        for (int i = 0; i < 9; i++) begin
            reset   = tbl[i].rst;
            tick_en = tbl[i].tick;
            cycle(tbl[i].wr, tbl[i].d);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].e_ovf);
            chk($sformatf("vec%0d_tx", i), tx, tbl[i].e_tx);
            chk($sformatf("vec%0d_busy", i), tx_busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_done", i), tx_done_tick, tbl[i].e_done);
        end
        reset = 1'b0;
        tick_en = 1;
        rxq.delete();
        done_edges.delete();
        run_until_rx("burst_rx_timeout", 5, 5000);
        for (int i = 0; i < 5; i++) chk_rx($sformatf("burst_byte%0d", i), i, 8'hA0 + 8'(i));
        chk("burst_done_count", done_edges.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (i < done_edges.size())
                chk($sformatf("burst_gap%0d", i), done_edges[i] - done_edges[i-1], 640);
        end
        chk("burst_empty_after", empty, 1'b1);

        // Single 0x55 frame, aligned so every bit spans 64 clk.
        do_reset();
        tick_en = 1;
        while ((edge_n + 1) % 4 != 3) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h55);
        chk("lat_empty_n1", empty, 1'b0);
        chk("lat_tx_n1", tx, 1'b1);
        frame55 = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) bad[b] = 0;
        for (int j = 0; j < 640; j++) begin
            cycle(1'b0, 8'h00);
            if (tx !== frame55[j/64]) bad[j/64]++;
        end
        for (int b = 0; b < 10; b++) chk($sformatf("f55_bit%0d_errs", b), bad[b], 0);
        cycle(1'b0, 8'h00);
        chk("f55_done_at_end", tx_done_tick, 1'b1);
        chk("f55_idle_tx", tx, 1'b1);
        for (int j = 0; j < 60; j++) cycle(1'b0, 8'h00);
        chk("f55_done_count", done_edges.size(), 1);
        chk("f55_rx_count", rxq.size(), 1);
        chk_rx("f55_rx_byte", 0, 8'h55);

        // Reset 300 clk into a 0xC3 frame with another byte queued.
        do_reset();
        tick_en = 1;
        cycle(1'b1, 8'hC3);
        cycle(1'b1, 8'h11);
        for (int j = 1; j < 300; j++) cycle(1'b0, 8'h00);
        reset = 1'b1;
        cycle(1'b0, 8'h00);
        reset = 1'b0;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_empty", empty, 1'b1);
        nbad = 0;
        for (int j = 0; j < 1500; j++) begin
            cycle(1'b0, 8'h00);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || empty !== 1'b1) nbad++;
        end
        chk("abort_stays_idle", nbad, 0);
        chk("abort_no_done", done_edges.size(), 0);
        chk("abort_no_rx", rxq.size(), 0);

        // s_tick frozen right after IDLE->START; writes still land.
        do_reset();
        tick_en = 1;
        cycle(1'b1, 8'h96);
        tick_en = 0;
        cycle(1'b0, 8'h00);
        nbad = 0;
        for (int j = 0; j < 1000; j++) begin
            cycle(j == 10, 8'h5A);
            if (tx !== 1'b0 || tx_busy !== 1'b1) nbad++;
        end
        chk("freeze_tx_low_busy", nbad, 0);
        chk("freeze_write_landed", empty, 1'b0);
        tick_en = 1;
        run_until_rx("freeze_rx_timeout", 2, 3000);
        chk_rx("freeze_byte0", 0, 8'h96);
        chk_rx("freeze_byte1", 1, 8'h5A);

        // Write coinciding with the pop after STOP, count held at 1.
        do_reset();
        tick_en = 1;
        cycle(1'b1, 8'h81);
        cycle(1'b1, 8'h42);
        c = 0;
        while (tx_done_tick !== 1'b1 && c < 1000) begin
            cycle(1'b0, 8'h00);
            c++;
        end
        chk("samecyc_done_seen", tx_done_tick, 1'b1);
        cycle(1'b1, 8'h3C);
        chk("samecyc_empty", empty, 1'b0);
        chk("samecyc_full", full, 1'b0);
        chk("samecyc_tx_start", tx, 1'b0);
        run_until_rx("samecyc_rx_timeout", 3, 3000);
        chk_rx("samecyc_byte0", 0, 8'h81);
        chk_rx("samecyc_byte1", 1, 8'h42);
        chk_rx("samecyc_byte2", 2, 8'h3C);
        chk("samecyc_empty_end", empty, 1'b1);

        // Randomized writes against the timeline model.
        do_reset();
        tick_en = 1;
        model_chk = 1;
        for (int i = 0; i < 4000; i++) begin
            case ((i / 500) % 4)
                0:       pm = 40;
                2:       pm = 3;
                default: pm = 0;
            endcase
            wr = ($urandom_range(0, 999) < pm);
            cycle(wr, 8'($urandom));
        end
        c = 0;
        while ((mq.size() > 0 || (m_active && edge_n < m_d)) && c < 8000) begin
            cycle(1'b0, 8'h00);
            c++;
        end
        chk("rand_drain_in_budget", c < 8000, 1'b1);
        for (int j = 0; j < 10; j++) cycle(1'b0, 8'h00);
        model_chk = 0;
        chk("rand_rx_count", rxq.size(), sentq.size());
        for (int i = 0; i < sentq.size(); i++) chk_rx($sformatf("rand_byte%0d", i), i, sentq[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
